// File: rtl/tlul_flat_bridge_if.sv
// Bus bundles for tlul_flat_bridge: the TL-UL host port and the flattened TileLink device port.
// Each interface's master modport is the side that drives the A channel.
interface tlul_h_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = 8,
  parameter int SZW = 2
);
  localparam int MW = DW / 8;

  logic           h_a_valid;
  logic           h_a_ready;
  logic [2:0]     h_a_opcode;
  logic [SZW-1:0] h_a_size;
  logic [SW-1:0]  h_a_source;
  logic [AW-1:0]  h_a_address;
  logic [MW-1:0]  h_a_mask;
  logic [DW-1:0]  h_a_data;
  logic           h_d_valid;
  logic           h_d_ready;
  logic [2:0]     h_d_opcode;
  logic [SZW-1:0] h_d_size;
  logic [SW-1:0]  h_d_source;
  logic [DW-1:0]  h_d_data;
  logic           h_d_error;

  modport master (
    output h_a_valid, h_a_opcode, h_a_size, h_a_source, h_a_address, h_a_mask, h_a_data,
    input  h_a_ready,
    input  h_d_valid, h_d_opcode, h_d_size, h_d_source, h_d_data, h_d_error,
    output h_d_ready
  );

  modport slave (
    input  h_a_valid, h_a_opcode, h_a_size, h_a_source, h_a_address, h_a_mask, h_a_data,
    output h_a_ready,
    output h_d_valid, h_d_opcode, h_d_size, h_d_source, h_d_data, h_d_error,
    input  h_d_ready
  );
endinterface

interface tlul_dev_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = 8,
  parameter int SZW = 2
);
  localparam int MW = DW / 8;

  logic           tl_a_valid;
  logic           tl_a_ready;
  logic [2:0]     tl_a_bits_opcode;
  logic [SZW-1:0] tl_a_bits_size;
  logic [SW-1:0]  tl_a_bits_source;
  logic [AW-1:0]  tl_a_bits_address;
  logic [MW-1:0]  tl_a_bits_mask;
  logic [DW-1:0]  tl_a_bits_data;
  logic [MW-1:0]  tl_a_bits_parity;
  logic           tl_a_bits_corrupt;
  logic           tl_d_valid;
  logic           tl_d_ready;
  logic [2:0]     tl_d_bits_opcode;
  logic [SZW-1:0] tl_d_bits_size;
  logic [SW-1:0]  tl_d_bits_source;
  logic [DW-1:0]  tl_d_bits_data;
  logic           tl_d_bits_corrupt;
  logic           tl_d_bits_denied;

  modport master (
    output tl_a_valid, tl_a_bits_opcode, tl_a_bits_size, tl_a_bits_source, tl_a_bits_address,
    output tl_a_bits_mask, tl_a_bits_data, tl_a_bits_parity, tl_a_bits_corrupt,
    input  tl_a_ready,
    input  tl_d_valid, tl_d_bits_opcode, tl_d_bits_size, tl_d_bits_source, tl_d_bits_data,
    input  tl_d_bits_corrupt, tl_d_bits_denied,
    output tl_d_ready
  );

  modport slave (
    input  tl_a_valid, tl_a_bits_opcode, tl_a_bits_size, tl_a_bits_source, tl_a_bits_address,
    input  tl_a_bits_mask, tl_a_bits_data, tl_a_bits_parity, tl_a_bits_corrupt,
    output tl_a_ready,
    output tl_d_valid, tl_d_bits_opcode, tl_d_bits_size, tl_d_bits_source, tl_d_bits_data,
    output tl_d_bits_corrupt, tl_d_bits_denied,
    input  tl_d_ready
  );
endinterface

// File: rtl/tlul_flat_bridge.sv
// Registered TL-UL host to flattened TileLink device bridge: request FIFO, one-entry
// response slice, outstanding limiter, optional odd byte parity, unexpected-response flag.
module tlul_flat_bridge #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SW       = 8,
  parameter int SZW      = 2,
  parameter int ReqDepth = 2,
  parameter int MaxOut   = 4,
  parameter int ParityEn = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tlul_h_if.slave     h,
  tlul_dev_if.master  tl,
  output logic [7:0]  outstanding_o,
  output logic        err_unexp_o
);
  localparam int MW = DW / 8;
  localparam int PW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int OW = $clog2(ReqDepth + 1);
  localparam logic [PW-1:0] LastPtr  = PW'(ReqDepth - 1);
  localparam logic [OW-1:0] OccFull  = OW'(ReqDepth);
  localparam logic [8:0]    MaxOutW  = 9'(MaxOut);

  typedef struct packed {
    logic [2:0]     opcode;
    logic [SZW-1:0] size;
    logic [SW-1:0]  source;
    logic [AW-1:0]  address;
    logic [MW-1:0]  mask;
    logic [DW-1:0]  data;
  } req_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  req_t            r_fifo_q [ReqDepth];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [OW-1:0]   r_occ;
  logic            r_init;
  logic [7:0]      r_cnt;
  logic            r_err;

  logic            r_d_vld_p1;
  logic [2:0]      r_d_opcode_p1;
  logic [SZW-1:0]  r_d_size_p1;
  logic [SW-1:0]   r_d_source_p1;
  logic [DW-1:0]   r_d_data_p1;
  logic            r_d_error_p1;

  req_t            w_req;
  req_t            w_head;
  logic            w_full;
  logic            w_push, w_pop;
  logic            w_d_fire, w_d_take, w_d_dec, w_h_d_fire;
  logic [8:0]      w_sum;
  logic [MW-1:0]   w_par;

  // ---- A path: host beat into FIFO (stage p0), FIFO head drives tl_a (stage p1)
  assign w_req  = '{opcode:  h.h_a_opcode,  size: h.h_a_size, source: h.h_a_source,
                    address: h.h_a_address, mask: h.h_a_mask, data:   h.h_a_data};
  assign w_head = r_fifo_q[r_rptr];
  assign w_full = (r_occ == OccFull);
  assign w_sum  = {1'b0, r_cnt} + 9'(r_occ);

  // r_init keeps the host stalled through reset and releases it one cycle later.
  assign h.h_a_ready = r_init && !w_full && (w_sum < MaxOutW);
  assign w_push      = h.h_a_valid && h.h_a_ready;
  assign w_pop       = tl.tl_a_valid && tl.tl_a_ready;

  assign tl.tl_a_valid        = (r_occ != '0);
  assign tl.tl_a_bits_opcode  = w_head.opcode;
  assign tl.tl_a_bits_size    = w_head.size;
  assign tl.tl_a_bits_source  = w_head.source;
  assign tl.tl_a_bits_address = w_head.address;
  assign tl.tl_a_bits_mask    = w_head.mask;
  assign tl.tl_a_bits_data    = w_head.data;
  assign tl.tl_a_bits_corrupt = 1'b0;

  for (genvar gi = 0; gi < MW; gi++) begin : g_par
    assign w_par[gi] = odd_par(w_head.data[8*gi +: 8]);
  end
  assign tl.tl_a_bits_parity = (ParityEn != 0) ? w_par : '0;

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_q[r_wptr] <= w_req;
  end

  // ---- D path: device beat captured into the response slice (stage p1)
  assign tl.tl_d_ready = !r_d_vld_p1 || h.h_d_ready;
  assign w_d_fire      = tl.tl_d_valid && tl.tl_d_ready;
  assign w_d_take      = w_d_fire && (r_cnt != 8'd0);
  assign w_d_dec       = w_d_take;
  assign w_h_d_fire    = r_d_vld_p1 && h.h_d_ready;

  always_ff @(posedge clk_i) begin
    if (w_d_take) begin
      r_d_opcode_p1 <= tl.tl_d_bits_opcode;
      r_d_size_p1   <= tl.tl_d_bits_size;
      r_d_source_p1 <= tl.tl_d_bits_source;
      r_d_data_p1   <= tl.tl_d_bits_data;
      r_d_error_p1  <= tl.tl_d_bits_corrupt | tl.tl_d_bits_denied;
    end
  end

  assign h.h_d_valid  = r_d_vld_p1;
  assign h.h_d_opcode = r_d_opcode_p1;
  assign h.h_d_size   = r_d_size_p1;
  assign h.h_d_source = r_d_source_p1;
  assign h.h_d_data   = r_d_data_p1;
  assign h.h_d_error  = r_d_error_p1;

  // ---- Control state: FIFO pointers, outstanding count, slice valid, error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_init     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_d_vld_p1 <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
      if (w_pop && !w_d_dec)      r_cnt <= r_cnt + 8'd1;
      else if (!w_pop && w_d_dec) r_cnt <= r_cnt - 8'd1;
      // A beat arriving with nothing outstanding is swallowed and flagged.
      if (w_d_fire && (r_cnt == 8'd0)) r_err <= 1'b1;
      if (w_d_take)        r_d_vld_p1 <= 1'b1;
      else if (w_h_d_fire) r_d_vld_p1 <= 1'b0;
    end
  end

  assign outstanding_o = r_cnt;
  assign err_unexp_o   = r_err;

endmodule

// File: tb/tb_tlul_flat_bridge.sv
// Directed bench for tlul_flat_bridge (ReqDepth=2, MaxOut=4, ParityEn=1).
module tb_tlul_flat_bridge;
  localparam int AW = 32, DW = 32, SW = 8, SZW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlul_h_if   #(.AW(AW), .DW(DW), .SW(SW), .SZW(SZW)) hif ();
  tlul_dev_if #(.AW(AW), .DW(DW), .SW(SW), .SZW(SZW)) dif ();
  logic [7:0] outst;
  logic       err;

  tlul_flat_bridge #(.AW(AW), .DW(DW), .SW(SW), .SZW(SZW),
                     .ReqDepth(2), .MaxOut(4), .ParityEn(1)) dut (
    .clk_i(clk), .rst_i(rst), .h(hif), .tl(dif),
    .outstanding_o(outst), .err_unexp_o(err));

  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    hif.h_a_valid = 0; hif.h_a_opcode = 0; hif.h_a_size = 0; hif.h_a_source = 0;
    hif.h_a_address = 0; hif.h_a_mask = 0; hif.h_a_data = 0; hif.h_d_ready = 1;
    dif.tl_a_ready = 0; dif.tl_d_valid = 0; dif.tl_d_bits_opcode = 0; dif.tl_d_bits_size = 0;
    dif.tl_d_bits_source = 0; dif.tl_d_bits_data = 0; dif.tl_d_bits_corrupt = 0;
    dif.tl_d_bits_denied = 0;
  endtask

  task automatic put_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] src);
    hif.h_a_valid = 1; hif.h_a_opcode = op; hif.h_a_size = 2'd2; hif.h_a_source = src;
    hif.h_a_address = addr; hif.h_a_mask = 4'hF; hif.h_a_data = data;
  endtask

  task automatic put_rsp(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data,
                         input logic cor, input logic den);
    dif.tl_d_valid = 1; dif.tl_d_bits_opcode = op; dif.tl_d_bits_size = 2'd2;
    dif.tl_d_bits_source = src; dif.tl_d_bits_data = data;
    dif.tl_d_bits_corrupt = cor; dif.tl_d_bits_denied = den;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    tick(); tick();
    n_vec++; if (hif.h_a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %b want 0", hif.h_a_ready); end
    n_vec++; if (dif.tl_a_valid !== 1'b0) begin n_err++; $display("FAIL rst_tl_a_valid: got %b want 0", dif.tl_a_valid); end
    n_vec++; if (hif.h_d_valid !== 1'b0) begin n_err++; $display("FAIL rst_h_d_valid: got %b want 0", hif.h_d_valid); end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL rst_outst: got %0d want 0", outst); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 0;
    #1;
    n_vec++; if (hif.h_a_ready !== 1'b0) begin n_err++; $display("FAIL rel_a_ready_early: got %b want 0", hif.h_a_ready); end
    tick();
    n_vec++; if (hif.h_a_ready !== 1'b1) begin n_err++; $display("FAIL rel_a_ready: got %b want 1", hif.h_a_ready); end
  endtask

  task automatic test_single_get;
    dif.tl_a_ready = 1;
    put_req(3'd4, 32'h1000, 32'h0, 8'd3);
    tick();
    hif.h_a_valid = 0;
    #1;
    n_vec++; if (dif.tl_a_valid !== 1'b1) begin n_err++; $display("FAIL get_a_valid: got %b want 1", dif.tl_a_valid); end
    n_vec++; if (dif.tl_a_bits_address !== 32'h1000) begin n_err++; $display("FAIL get_addr: got %h want 00001000", dif.tl_a_bits_address); end
    n_vec++; if (dif.tl_a_bits_opcode !== 3'd4) begin n_err++; $display("FAIL get_opcode: got %0d want 4", dif.tl_a_bits_opcode); end
    n_vec++; if (dif.tl_a_bits_source !== 8'd3) begin n_err++; $display("FAIL get_source: got %0d want 3", dif.tl_a_bits_source); end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL get_outst0: got %0d want 0", outst); end
    tick();
    n_vec++; if (dif.tl_a_valid !== 1'b0) begin n_err++; $display("FAIL get_a_drained: got %b want 0", dif.tl_a_valid); end
    n_vec++; if (outst !== 8'd1) begin n_err++; $display("FAIL get_outst1: got %0d want 1", outst); end
    put_rsp(3'd1, 8'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    dif.tl_d_valid = 0;
    #1;
    n_vec++; if (hif.h_d_valid !== 1'b1) begin n_err++; $display("FAIL get_d_valid: got %b want 1", hif.h_d_valid); end
    n_vec++; if (hif.h_d_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL get_d_data: got %h want deadbeef", hif.h_d_data); end
    n_vec++; if (hif.h_d_source !== 8'd3) begin n_err++; $display("FAIL get_d_source: got %0d want 3", hif.h_d_source); end
    n_vec++; if (hif.h_d_opcode !== 3'd1) begin n_err++; $display("FAIL get_d_opcode: got %0d want 1", hif.h_d_opcode); end
    n_vec++; if (hif.h_d_error !== 1'b0) begin n_err++; $display("FAIL get_d_error: got %b want 0", hif.h_d_error); end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL get_outst_back: got %0d want 0", outst); end
    tick();
    n_vec++; if (hif.h_d_valid !== 1'b0) begin n_err++; $display("FAIL get_d_released: got %b want 0", hif.h_d_valid); end
    dif.tl_a_ready = 0;
  endtask

  task automatic test_max_outstanding;
    int acc, iss;
    acc = 0; iss = 0;
    dif.tl_a_ready = 1;
    for (int c = 0; c < 10; c++) begin
      put_req(3'd0, 32'h2000 + 32'(acc) * 4, 32'(acc), 8'(acc));
      hif.h_a_valid = (acc < 6);
      #1;
      if (hif.h_a_valid && hif.h_a_ready) acc++;
      if (dif.tl_a_valid && dif.tl_a_ready) iss++;
      tick();
    end
    put_req(3'd0, 32'h2000 + 32'(acc) * 4, 32'(acc), 8'(acc));
    #1;
    n_vec++; if (acc != 4) begin n_err++; $display("FAIL max_accepted: got %0d want 4", acc); end
    n_vec++; if (iss != 4) begin n_err++; $display("FAIL max_issued: got %0d want 4", iss); end
    n_vec++; if (outst !== 8'd4) begin n_err++; $display("FAIL max_outst: got %0d want 4", outst); end
    n_vec++; if (hif.h_a_ready !== 1'b0) begin n_err++; $display("FAIL max_a_ready_low: got %b want 0", hif.h_a_ready); end
    put_rsp(3'd0, 8'd0, 32'h11, 1'b0, 1'b0);
    tick();
    dif.tl_d_valid = 0;
    #1;
    n_vec++; if (outst !== 8'd3) begin n_err++; $display("FAIL max_outst_after_ack: got %0d want 3", outst); end
    n_vec++; if (hif.h_a_ready !== 1'b1) begin n_err++; $display("FAIL max_a_ready_again: got %b want 1", hif.h_a_ready); end
    tick();
    hif.h_a_valid = 0;
    #1;
    n_vec++; if (dif.tl_a_valid !== 1'b1) begin n_err++; $display("FAIL max_fifth_valid: got %b want 1", dif.tl_a_valid); end
    n_vec++; if (dif.tl_a_bits_data !== 32'd4) begin n_err++; $display("FAIL max_fifth_data: got %h want 4", dif.tl_a_bits_data); end
    tick();
    n_vec++; if (outst !== 8'd4) begin n_err++; $display("FAIL max_outst_refill: got %0d want 4", outst); end
    dif.tl_a_ready = 0;
    for (int k = 0; k < 4; k++) begin
      put_rsp(3'd0, 8'(k), 32'hC0 + 32'(k), 1'b0, 1'b0);
      #1;
      n_vec++; if (dif.tl_d_ready !== 1'b1) begin n_err++; $display("FAIL b2b_d_ready%0d: got %b want 1", k, dif.tl_d_ready); end
      tick();
      n_vec++; if (hif.h_d_valid !== 1'b1 || hif.h_d_data !== 32'hC0 + 32'(k)) begin
        n_err++; $display("FAIL b2b_beat%0d: got valid %b data %h want valid 1 data %h", k, hif.h_d_valid, hif.h_d_data, 32'hC0 + 32'(k)); end
    end
    dif.tl_d_valid = 0;
    #1;
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL b2b_outst: got %0d want 0", outst); end
    tick();
    n_vec++; if (hif.h_d_valid !== 1'b0) begin n_err++; $display("FAIL b2b_d_idle: got %b want 0", hif.h_d_valid); end
  endtask

  task automatic test_backpressure;
    dif.tl_a_ready = 0;
    put_req(3'd1, 32'h3000, 32'hA0A0A0A0, 8'd5);
    tick();
    put_req(3'd1, 32'h3004, 32'hB0B0B0B0, 8'd6);
    tick();
    put_req(3'd1, 32'h3008, 32'hC0C0C0C0, 8'd7);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (hif.h_a_ready !== 1'b0 || dif.tl_a_valid !== 1'b1 || dif.tl_a_bits_data !== 32'hA0A0A0A0 || dif.tl_a_bits_source !== 8'd5) begin
        n_err++; $display("FAIL bp_hold%0d: got rdy %b vld %b data %h src %0d want rdy 0 vld 1 data a0a0a0a0 src 5",
                          c, hif.h_a_ready, dif.tl_a_valid, dif.tl_a_bits_data, dif.tl_a_bits_source); end
      tick();
    end
    hif.h_a_valid = 0;
    dif.tl_a_ready = 1;
    #1;
    n_vec++; if (dif.tl_a_bits_data !== 32'hA0A0A0A0) begin n_err++; $display("FAIL bp_first: got %h want a0a0a0a0", dif.tl_a_bits_data); end
    tick();
    n_vec++; if (dif.tl_a_valid !== 1'b1 || dif.tl_a_bits_data !== 32'hB0B0B0B0 || dif.tl_a_bits_source !== 8'd6) begin
      n_err++; $display("FAIL bp_second: got vld %b data %h src %0d want vld 1 data b0b0b0b0 src 6", dif.tl_a_valid, dif.tl_a_bits_data, dif.tl_a_bits_source); end
    tick();
    n_vec++; if (dif.tl_a_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", dif.tl_a_valid); end
    n_vec++; if (outst !== 8'd2) begin n_err++; $display("FAIL bp_outst: got %0d want 2", outst); end
    dif.tl_a_ready = 0;
    put_rsp(3'd0, 8'd5, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    dif.tl_d_valid = 0;
    tick();
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL bp_drain: got %0d want 0", outst); end
  endtask

  task automatic test_parity;
    dif.tl_a_ready = 1;
    put_req(3'd1, 32'h4000, 32'h01FF0300, 8'd9);
    tick();
    hif.h_a_valid = 0;
    #1;
    n_vec++; if (dif.tl_a_bits_parity !== 4'b0111) begin n_err++; $display("FAIL par_01ff0300: got %b want 0111", dif.tl_a_bits_parity); end
    n_vec++; if (dif.tl_a_bits_corrupt !== 1'b0) begin n_err++; $display("FAIL par_corrupt: got %b want 0", dif.tl_a_bits_corrupt); end
    put_req(3'd1, 32'h4004, 32'h00000000, 8'd10);
    tick();
    hif.h_a_valid = 0;
    #1;
    n_vec++; if (dif.tl_a_bits_parity !== 4'b1111) begin n_err++; $display("FAIL par_zero: got %b want 1111", dif.tl_a_bits_parity); end
    tick();
    dif.tl_a_ready = 0;
    put_rsp(3'd0, 8'd9, 32'h0, 1'b0, 1'b1);
    tick();
    put_rsp(3'd0, 8'd10, 32'h0, 1'b1, 1'b0);
    #1;
    n_vec++; if (hif.h_d_valid !== 1'b1 || hif.h_d_error !== 1'b1) begin
      n_err++; $display("FAIL par_denied_err: got vld %b err %b want 1 1", hif.h_d_valid, hif.h_d_error); end
    tick();
    dif.tl_d_valid = 0; dif.tl_d_bits_corrupt = 0; dif.tl_d_bits_denied = 0;
    #1;
    n_vec++; if (hif.h_d_valid !== 1'b1 || hif.h_d_error !== 1'b1 || hif.h_d_source !== 8'd10) begin
      n_err++; $display("FAIL par_corrupt_err: got vld %b err %b src %0d want 1 1 10", hif.h_d_valid, hif.h_d_error, hif.h_d_source); end
    tick();
  endtask

  task automatic test_unexpected_and_reset;
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL unexp_pre_outst: got %0d want 0", outst); end
    put_rsp(3'd1, 8'd2, 32'h55, 1'b0, 1'b0);
    #1;
    n_vec++; if (dif.tl_d_ready !== 1'b1) begin n_err++; $display("FAIL unexp_d_ready: got %b want 1", dif.tl_d_ready); end
    tick();
    dif.tl_d_valid = 0;
    #1;
    n_vec++; if (hif.h_d_valid !== 1'b0) begin n_err++; $display("FAIL unexp_dropped: got %b want 0", hif.h_d_valid); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL unexp_err: got %b want 1", err); end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL unexp_outst: got %0d want 0", outst); end
    tick(); tick(); tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL unexp_sticky: got %b want 1", err); end
    dif.tl_a_ready = 1;
    put_req(3'd4, 32'h5000, 32'h0, 8'd1);
    tick();
    hif.h_a_valid = 0;
    tick();
    dif.tl_a_ready = 0;
    put_req(3'd4, 32'h5004, 32'h0, 8'd2);
    tick();
    hif.h_a_valid = 0;
    hif.h_d_ready = 0;
    put_rsp(3'd1, 8'd1, 32'h77, 1'b0, 1'b0);
    tick();
    dif.tl_d_valid = 0;
    #1;
    n_vec++; if (hif.h_d_valid !== 1'b1 || dif.tl_a_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got d_vld %b a_vld %b want 1 1", hif.h_d_valid, dif.tl_a_valid); end
    rst = 1;
    #1;
    n_vec++; if (dif.tl_a_valid !== 1'b0) begin n_err++; $display("FAIL mid_a_valid: got %b want 0", dif.tl_a_valid); end
    n_vec++; if (hif.h_d_valid !== 1'b0) begin n_err++; $display("FAIL mid_d_valid: got %b want 0", hif.h_d_valid); end
    n_vec++; if (hif.h_a_ready !== 1'b0) begin n_err++; $display("FAIL mid_a_ready: got %b want 0", hif.h_a_ready); end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL mid_outst: got %0d want 0", outst); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", err); end
    tick(); tick();
    idle_inputs();
    rst = 0;
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    int idx, rcv;
    logic [31:0] got [8];
    for (int k = 0; k < 8; k++) got[k] = '0;
    dif.tl_a_ready = 1;
    for (int k = 0; k < 4; k++) begin
      put_req(3'd4, 32'h6000 + 32'(k) * 4, 32'h0, 8'(k));
      tick();
    end
    hif.h_a_valid = 0;
    tick();
    dif.tl_a_ready = 0;
    n_vec++; if (outst !== 8'd4) begin n_err++; $display("FAIL tog_outst4: got %0d want 4", outst); end
    idx = 0; rcv = 0;
    for (int c = 0; c < 40; c++) begin
      hif.h_d_ready = (c % 2 == 0);
      if (idx < 4) put_rsp(3'd1, 8'(idx), 32'hD00 + 32'(idx), 1'b0, 1'b0);
      else dif.tl_d_valid = 0;
      #1;
      if (dif.tl_d_valid && dif.tl_d_ready) idx++;
      if (hif.h_d_valid && hif.h_d_ready) begin
        if (rcv < 8) got[rcv] = hif.h_d_data;
        rcv++;
      end
      tick();
    end
    dif.tl_d_valid = 0;
    hif.h_d_ready = 1;
    n_vec++; if (rcv != 4) begin n_err++; $display("FAIL tog_count: got %0d want 4", rcv); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (got[k] !== 32'hD00 + 32'(k)) begin n_err++; $display("FAIL tog_beat%0d: got %h want %h", k, got[k], 32'hD00 + 32'(k)); end
    end
    n_vec++; if (outst !== 8'd0) begin n_err++; $display("FAIL tog_outst0: got %0d want 0", outst); end
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_max_outstanding();
    test_backpressure();
    test_parity();
    test_unexpected_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
